imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, registered immediate generator for the decode stage. Extracts and sign/zero-extends the immediate of any RV32/RV64 base-ISA format to XLEN bits. A 2-entry skid buffer with valid/ready on both sides lets decode stall without combinational ready paths. Sits between the fetch/decode register and the operand-select mux.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous pipeline flush; discards all buffered entries
- in_valid  in  1  input beat valid
- in_ready  out  1  buffer can accept a beat; registered
- in_instr  in  32  raw instruction word
- in_imm_src  in  3  format select (encoding below)
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the beat
- out_imm  out  XLEN  extended immediate
- out_instr  out  32  instruction passed through with its immediate
- out_err  out  1  illegal format select or illegal shamt for XLEN

## Operation
- Format encoding; 000–011 keep the legacy 2-bit meaning:
  - 000 I: sext(instr[31:20])
  - 001 S: sext({instr[31:25], instr[11:7]})
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - 100 U: sext({instr[31:12], 12'b0}); at XLEN=64 bit 31 is replicated upward
  - 101 Z: zext(instr[19:15]) (CSR uimm)
  - 110 SH: zext(instr[25:20]); at XLEN=32, instr[25]=1 sets out_err
  - 111: out_imm=0, out_err=1
- Sign extension always replicates instr[31] to bit XLEN-1.
- Decode is combinational at the input. The buffer stores {imm, instr, err}.
- Buffer states:
  - EMPTY: out_valid=0
  - ONE: output register valid
  - FULL: output register and skid register valid
- Transitions (accept = in_valid & in_ready, drain = out_valid & out_ready):
  - EMPTY + accept -> ONE
  - ONE + accept + drain -> ONE (output register reloads)
  - ONE + accept, no drain -> FULL (beat goes to skid)
  - ONE + drain, no accept -> EMPTY
  - FULL + drain -> ONE (skid moves to output; no accept possible because in_ready=0)
- in_ready = (state != FULL), registered.
- flush has priority over everything. The next state is EMPTY and any same-cycle input beat is dropped.
- Reset has priority over flush. Reset values: out_valid=0, out_imm=0, out_instr=0, out_err=0, in_ready=1, state EMPTY. Beats presented while rst_n=0 are ignored.
- out_imm/out_instr/out_err hold their values while out_valid=1 & out_ready=0.

## Timing
- Latency: 1 cycle from accept to out_valid when EMPTY or draining.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready falls the cycle after the beat that filled the skid. It rises the cycle after the skid drains.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- After flush: out_valid=0 and in_ready=1 on the next edge.
- Reset mid-stream drops all beats with no partial output.

## Structure
- Shared package imm_pkg holds:
  - enum imm_src_e with the 3-bit encoding
  - localparams for legal XLEN values
  - buffer state enum
- Sub-module imm_decode(XLEN) is purely combinational: instr and imm_src in, imm and err out. It is instantiated once at the input, and the format logic is unit-tested there.
- Top level contains only the skid buffer FSM and registers.
- An XLEN outside {32, 64} raises an elaboration-time error.

## Test plan
- I, XLEN=32: instr 0xFFF00093, src 000 -> out_imm 0xFFFFFFFF, err 0, one cycle after accept.
- S and B, XLEN=32:
  - 0xFE20AE23, src 001 -> 0xFFFFFFFC
  - 0xFE000EE3, src 010 -> 0xFFFFFFFC
- U, XLEN=64: 0x800000B7, src 100 -> 0xFFFFFFFF80000000. SH with 0x02009093 -> imm 0x20 and err 0 at XLEN=64, err 1 at XLEN=32.
- Backpressure: send A, B, C back-to-back with out_ready=0 for 3 cycles.
  - A is held on the output and B sits in the skid.
  - in_ready goes 0 the cycle after B is accepted, so C waits at the source.
  - On release, the output order is A, B, C with no loss or duplication.
- Flush with FULL buffer and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; that input beat never appears.
- Illegal src 111 with any instr -> out_imm 0, out_err 1. Assert rst_n=0 while FULL -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format select encoding,
// legal datapath widths and skid buffer states.
package imm_pkg;

  localparam int unsigned XLEN_32 = 32;
  localparam int unsigned XLEN_64 = 64;

  typedef enum logic [2:0] {
    SRC_I   = 3'b000,
    SRC_S   = 3'b001,
    SRC_B   = 3'b010,
    SRC_J   = 3'b011,
    SRC_U   = 3'b100,
    SRC_Z   = 3'b101,
    SRC_SH  = 3'b110,
    SRC_ILL = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension for all base-ISA formats.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [31:0] raw;

  // Every format is first built as a 32-bit value already extended to bit 31,
  // then sign-extended to XLEN; zext formats have bit 31 clear.
  always_comb begin
    raw = '0;
    err = 1'b0;
    case (imm_src_e'(imm_src))
      SRC_I:  raw = {{20{instr[31]}}, instr[31:20]};
      SRC_S:  raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SRC_B:  raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                     instr[11:8], 1'b0};
      SRC_J:  raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
      SRC_U:  raw = {instr[31:12], 12'b0};
      SRC_Z:  raw = {27'b0, instr[19:15]};
      SRC_SH: begin
        raw = {26'b0, instr[25:20]};
        err = (XLEN == XLEN_32) && instr[25];
      end
      default: begin
        raw = '0;
        err = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: input decode feeding a 2-entry skid buffer
// with registered in_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [31:0]     out_instr,
  output logic            out_err
);

  if ((XLEN != XLEN_32) && (XLEN != XLEN_64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (dec_imm),
    .err     (dec_err)
  );

  buf_state_e      state;
  logic [XLEN-1:0] skid_imm;
  logic [31:0]     skid_instr;
  logic            skid_err;
  logic            accept;
  logic            drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_instr  <= '0;
      out_err    <= 1'b0;
      in_ready   <= 1'b1;
      skid_imm   <= '0;
      skid_instr <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_imm   <= dec_imm;
            out_instr <= in_instr;
            out_err   <= dec_err;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_imm   <= dec_imm;
            out_instr <= in_instr;
            out_err   <= dec_err;
          end else if (accept) begin
            skid_imm   <= dec_imm;
            skid_instr <= in_instr;
            skid_err   <= dec_err;
            in_ready   <= 1'b0;
            state      <= ST_FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            out_imm   <= skid_imm;
            out_instr <= skid_instr;
            out_err   <= skid_err;
            in_ready  <= 1'b1;
            state     <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench driving an XLEN=32 and an XLEN=64 instance from shared inputs.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32, out_instr32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [31:0] out_instr64;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_src(in_imm_src),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_instr(out_instr32), .out_err(out_err32)
  );

  imm_gen_pipe #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_instr(out_instr64), .out_err(out_err64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge, then deassert in_valid.
  task automatic send(input logic [31:0] instr, input logic [2:0] src);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_imm_src = src;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00100093; in_imm_src = 3'b000;
    tick(); tick();
    check("rst_valid32", 64'(out_valid32), 64'd0);
    check("rst_ready32", 64'(in_ready32), 64'd1);
    check("rst_imm64", out_imm64, 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_ignored", 64'(out_valid32), 64'd0);

    // Single beats, draining every cycle
    send(32'hFFF00093, 3'b000);
    check("I_valid", 64'(out_valid32), 64'd1);
    check("I_imm32", 64'(out_imm32), 64'h0000_0000_FFFF_FFFF);
    check("I_err32", 64'(out_err32), 64'd0);
    check("I_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    send(32'hFE20AE23, 3'b001);
    check("S_imm32", 64'(out_imm32), 64'h0000_0000_FFFF_FFFC);
    send(32'hFE000EE3, 3'b010);
    check("B_imm32", 64'(out_imm32), 64'h0000_0000_FFFF_FFFC);
    send(32'h008000EF, 3'b011);
    check("J_imm64", out_imm64, 64'd8);
    send(32'h800000B7, 3'b100);
    check("U_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    check("U_imm32", 64'(out_imm32), 64'h0000_0000_8000_0000);
    send(32'h000F8000, 3'b101);
    check("Z_imm64", out_imm64, 64'd31);
    send(32'h02009093, 3'b110);
    check("SH_imm64", out_imm64, 64'h20);
    check("SH_err64", 64'(out_err64), 64'd0);
    check("SH_imm32", 64'(out_imm32), 64'h20);
    check("SH_err32", 64'(out_err32), 64'd1);
    send(32'hFFFFFFFF, 3'b111);
    check("ILL_imm64", out_imm64, 64'd0);
    check("ILL_err64", 64'(out_err64), 64'd1);
    tick();
    check("drain_empty", 64'(out_valid32), 64'd0);

    // Backpressure: A, B, C with out_ready low for three edges
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm_src = 3'b000;
    in_instr = 32'h00100093;
    tick();
    check("bp_A_valid", 64'(out_valid32), 64'd1);
    check("bp_ready_one", 64'(in_ready32), 64'd1);
    in_instr = 32'h00200093;
    tick();
    check("bp_ready_full", 64'(in_ready32), 64'd0);
    check("bp_hold_A", 64'(out_instr32), 64'h00100093);
    in_instr = 32'h00300093;
    tick();
    check("bp_still_A", 64'(out_instr64), 64'h00100093);
    check("bp_imm_A", out_imm64, 64'd1);
    check("bp_C_blocked", 64'(in_ready64), 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_out_B", 64'(out_instr32), 64'h00200093);
    check("bp_imm_B", 64'(out_imm32), 64'd2);
    check("bp_ready_back", 64'(in_ready32), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_out_C", 64'(out_instr32), 64'h00300093);
    check("bp_imm_C", out_imm64, 64'd3);
    tick();
    check("bp_done", 64'(out_valid32), 64'd0);

    // Flush with the buffer full and a beat on the input
    out_ready = 1'b0;
    send(32'h00400093, 3'b000);
    send(32'h00500093, 3'b000);
    check("fl_full", 64'(in_ready32), 64'd0);
    out_ready = 1'b1;
    tick();
    check("fl_drained_one", 64'(in_ready32), 64'd1);
    out_ready = 1'b0;
    send(32'h00600093, 3'b000);
    check("fl_full_again", 64'(in_ready32), 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00700093;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_valid", 64'(out_valid32), 64'd0);
    check("fl_ready", 64'(in_ready32), 64'd1);
    tick();
    check("fl_dropped", 64'(out_valid64), 64'd0);

    // Reset while full, with an error beat on the output
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 3'b111);
    check("rf_err", 64'(out_err32), 64'd1);
    send(32'h00800093, 3'b000);
    check("rf_full", 64'(in_ready32), 64'd0);
    rst_n = 1'b0;
    tick();
    check("rf_valid", 64'(out_valid32), 64'd0);
    check("rf_imm", 64'(out_imm32), 64'd0);
    check("rf_instr", 64'(out_instr32), 64'd0);
    check("rf_err_clr", 64'(out_err32), 64'd0);
    check("rf_ready", 64'(in_ready32), 64'd1);
    check("rf_imm64", out_imm64, 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    check("rf_no_partial", 64'(out_valid64), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
